// File: rtl/add_sub_pkg.sv
// Shared types and command encodings for the add/sub counter and its decoder.
package add_sub_pkg;

    typedef enum logic [1:0] {
        S_SYNC,
        S_FIRST,
        S_TRACK
    } state_t;

    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_UP,
        STEP_DOWN,
        STEP_ILLEGAL
    } step_t;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Command that produces a given legal step; only meaningful for UP/DOWN.
    function automatic logic step_to_cmd(input step_t step);
        return (step == STEP_DOWN) ? SUB : ADD;
    endfunction

endpackage

// File: rtl/add_sub_step_classifier.sv
// Classifies the transition prev -> value of a modulo-2^WIDTH counter.
module add_sub_step_classifier
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev_i,
    input  logic [WIDTH-1:0] value_i,
    output step_t            step_o
);

    logic [WIDTH-1:0] delta;

    always_comb begin
        delta  = value_i - prev_i;
        step_o = STEP_ILLEGAL;
        // UP is tested before DOWN so a 1-bit counter (where +1 == -1) reads as UP.
        if (delta == '0) begin
            step_o = STEP_HOLD;
        end else if (delta == WIDTH'(1)) begin
            step_o = STEP_UP;
        end else if (delta == '1) begin
            step_o = STEP_DOWN;
        end
    end

endmodule

// File: rtl/add_sub_decoder.sv
// Recovers add/subtract commands from an observed counter value stream and
// reports direction changes, run length and illegal steps.
module add_sub_decoder
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned RUN_W = 8,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             sample_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             valid_o,
    output logic             addsub_o,
    output logic             dir_change_o,
    output logic [RUN_W-1:0] run_len_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    state_t           state_q;
    logic [WIDTH-1:0] prev_q;
    logic             valid_q;
    logic             addsub_q;
    logic             dir_change_q;
    logic [RUN_W-1:0] run_len_q;
    logic             err_q;
    logic [ERR_W-1:0] err_cnt_q;

    step_t            step;
    logic             step_cmd_d;
    logic [RUN_W-1:0] run_len_inc_d;
    logic [ERR_W-1:0] err_cnt_inc_d;

    add_sub_step_classifier #(
        .WIDTH (WIDTH)
    ) u_classifier (
        .prev_i  (prev_q),
        .value_i (value_i),
        .step_o  (step)
    );

    always_comb begin
        step_cmd_d    = step_to_cmd(step);
        run_len_inc_d = (run_len_q == '1) ? run_len_q : run_len_q + RUN_W'(1);
        err_cnt_inc_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_SYNC;
            prev_q       <= '0;
            valid_q      <= 1'b0;
            addsub_q     <= ADD;
            dir_change_q <= 1'b0;
            run_len_q    <= '0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            valid_q      <= 1'b0;
            dir_change_q <= 1'b0;
            err_q        <= 1'b0;
            if (sample_i) begin
                prev_q <= value_i;
                unique case (state_q)
                    S_SYNC: begin
                        state_q <= S_FIRST;
                    end
                    S_FIRST: begin
                        unique case (step)
                            STEP_UP, STEP_DOWN: begin
                                valid_q   <= 1'b1;
                                addsub_q  <= step_cmd_d;
                                run_len_q <= RUN_W'(1);
                                state_q   <= S_TRACK;
                            end
                            STEP_ILLEGAL: begin
                                err_q     <= 1'b1;
                                err_cnt_q <= err_cnt_inc_d;
                                run_len_q <= '0;
                                state_q   <= S_SYNC;
                            end
                            default: ;
                        endcase
                    end
                    S_TRACK: begin
                        unique case (step)
                            STEP_UP, STEP_DOWN: begin
                                valid_q <= 1'b1;
                                if (step_cmd_d == addsub_q) begin
                                    run_len_q <= run_len_inc_d;
                                end else begin
                                    dir_change_q <= 1'b1;
                                    addsub_q     <= step_cmd_d;
                                    run_len_q    <= RUN_W'(1);
                                end
                            end
                            STEP_ILLEGAL: begin
                                err_q     <= 1'b1;
                                err_cnt_q <= err_cnt_inc_d;
                                run_len_q <= '0;
                                state_q   <= S_SYNC;
                            end
                            default: ;
                        endcase
                    end
                    default: begin
                        state_q <= S_SYNC;
                    end
                endcase
            end
        end
    end

    assign valid_o      = valid_q;
    assign addsub_o     = addsub_q;
    assign dir_change_o = dir_change_q;
    assign run_len_o    = run_len_q;
    assign err_o        = err_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_add_sub_decoder.sv
// Directed-vector bench for add_sub_decoder with narrow counters to reach saturation.
module tb_add_sub_decoder;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned RUN_W = 3;
    localparam int unsigned ERR_W = 2;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic             sample_i;
    logic [WIDTH-1:0] value_i;
    logic             valid_o;
    logic             addsub_o;
    logic             dir_change_o;
    logic [RUN_W-1:0] run_len_o;
    logic             err_o;
    logic [ERR_W-1:0] err_cnt_o;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    add_sub_decoder #(
        .WIDTH (WIDTH),
        .RUN_W (RUN_W),
        .ERR_W (ERR_W)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .sample_i     (sample_i),
        .value_i      (value_i),
        .valid_o      (valid_o),
        .addsub_o     (addsub_o),
        .dir_change_o (dir_change_o),
        .run_len_o    (run_len_o),
        .err_o        (err_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int unsigned v, input int unsigned a,
                              input int unsigned dc, input int unsigned run,
                              input int unsigned e, input int unsigned ecnt);
        check_eq({tag, ".valid"},  valid_o,      v);
        check_eq({tag, ".addsub"}, addsub_o,     a);
        check_eq({tag, ".dirchg"}, dir_change_o, dc);
        check_eq({tag, ".runlen"}, run_len_o,    run);
        check_eq({tag, ".err"},    err_o,        e);
        check_eq({tag, ".errcnt"}, err_cnt_o,    ecnt);
    endtask

    // One accepted sample; outputs are checked 1 time unit after the edge.
    task automatic smp(input string tag, input logic [WIDTH-1:0] v,
                       input int unsigned ev, input int unsigned ea, input int unsigned edc,
                       input int unsigned erun, input int unsigned ee, input int unsigned ecnt);
        sample_i = 1'b1;
        value_i  = v;
        @(posedge clk_i);
        #1;
        sample_i = 1'b0;
        check_outs(tag, ev, ea, edc, erun, ee, ecnt);
    endtask

    task automatic do_reset(input string tag);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        check_outs(tag, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset_i  = 1'b0;
        sample_i = 1'b0;
        value_i  = '0;
        #2;

        do_reset("rst0");
        smp("up0", 4'd0, 0, 0, 0, 0, 0, 0);
        smp("up1", 4'd1, 1, 0, 0, 1, 0, 0);
        smp("up2", 4'd2, 1, 0, 0, 2, 0, 0);
        smp("up3", 4'd3, 1, 0, 0, 3, 0, 0);

        do_reset("rst1");
        smp("uw14", 4'd14, 0, 0, 0, 0, 0, 0);
        smp("uw15", 4'd15, 1, 0, 0, 1, 0, 0);
        smp("uw0",  4'd0,  1, 0, 0, 2, 0, 0);
        smp("uw1",  4'd1,  1, 0, 0, 3, 0, 0);

        do_reset("rst2");
        smp("dw1",  4'd1,  0, 0, 0, 0, 0, 0);
        smp("dw0",  4'd0,  1, 1, 0, 1, 0, 0);
        smp("dw15", 4'd15, 1, 1, 0, 2, 0, 0);

        do_reset("rst3");
        smp("dc5a", 4'd5, 0, 0, 0, 0, 0, 0);
        smp("dc6a", 4'd6, 1, 0, 0, 1, 0, 0);
        smp("dc7",  4'd7, 1, 0, 0, 2, 0, 0);
        smp("dc6b", 4'd6, 1, 1, 1, 1, 0, 0);
        smp("dc5b", 4'd5, 1, 1, 0, 2, 0, 0);

        do_reset("rst4");
        smp("il3",  4'd3,  0, 0, 0, 0, 0, 0);
        smp("il4",  4'd4,  1, 0, 0, 1, 0, 0);
        smp("il9",  4'd9,  0, 0, 0, 0, 1, 1);
        smp("il10", 4'd10, 0, 0, 0, 0, 0, 1);
        smp("il11", 4'd11, 1, 0, 0, 1, 0, 1);
        smp("il0",  4'd0,  0, 0, 0, 0, 1, 2);
        smp("il2r", 4'd2,  0, 0, 0, 0, 0, 2);
        smp("il8",  4'd8,  0, 0, 0, 0, 1, 3);

        do_reset("rst5");
        smp("ho7",  4'd7, 0, 0, 0, 0, 0, 0);
        smp("ho8a", 4'd8, 1, 0, 0, 1, 0, 0);
        smp("ho8b", 4'd8, 0, 0, 0, 1, 0, 0);
        value_i = 4'd2;
        @(posedge clk_i);
        #1;
        check_outs("gated", 0, 0, 0, 1, 0, 0);
        smp("ho9",  4'd9, 1, 0, 0, 2, 0, 0);

        do_reset("rst6");
        smp("rm0", 4'd0, 0, 0, 0, 0, 0, 0);
        smp("rm1", 4'd1, 1, 0, 0, 1, 0, 0);
        smp("rm2", 4'd2, 1, 0, 0, 2, 0, 0);
        smp("rm3", 4'd3, 1, 0, 0, 3, 0, 0);
        sample_i = 1'b1;
        value_i  = 4'd4;
        do_reset("rstmid");
        smp("rm12", 4'd12, 0, 0, 0, 0, 0, 0);
        smp("rm13", 4'd13, 1, 0, 0, 1, 0, 0);

        do_reset("rst7");
        smp("sat0", 4'd0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            smp($sformatf("sat%0d", i), WIDTH'(i), 1, 0, 0, (i < 7) ? i : 7, 0, 0);
        end
        for (int i = 1; i <= 4; i++) begin
            smp($sformatf("esat_bad%0d", i), 4'd0, 0, 0, 0, 0, 1, (i < 3) ? i : 3);
            smp($sformatf("esat_ref%0d", i), 4'd5, 0, 0, 0, 0, 0, (i < 3) ? i : 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
